control_unit: RTL and testbench

- Multicycle main control FSM for the RV32I core.
- Decodes the opcode field of the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives datapath mux selects, PC/IR/register-file write enables and the memory request handshake.
- Produces the 2-bit aluop consumed by the ALU control stage: 00 add, 01 branch compare, 10 funct-decoded.

---
 rtl/control_unit_pkg.sv | 74 +++++++
 rtl/control_unit_if.sv | 36 +++
 rtl/control_unit_mem_wait_timer.sv | 32 +++
 rtl/control_unit.sv | 164 ++++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, state encodings and select codes for the RV32I main control
package control_unit_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_EXEC_R     = 4'd2,
    S_EXEC_I     = 4'd3,
    S_EXEC_LUI   = 4'd4,
    S_EXEC_AUIPC = 4'd5,
    S_ALU_WB     = 4'd6,
    S_BRANCH     = 4'd7,
    S_JAL        = 4'd8,
    S_EXEC_JALR  = 4'd9,
    S_JALR_WB    = 4'd10,
    S_MEM_ADDR   = 4'd11,
    S_MEM_READ   = 4'd12,
    S_MEM_WB     = 4'd13,
    S_MEM_WRITE  = 4'd14
  } state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_PC_OLD = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;

  localparam logic [1:0] M2R_ALU      = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;

  typedef struct packed {
    logic       memory_read;
    logic       memory_write;
    logic       lord;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic [1:0] aluop;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       is_immediate;
    logic       reg_write;
    logic [1:0] memory_to_reg;
    logic       illegal_instr;
    logic       bus_error;
  } ctrl_out_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit <-> datapath/memory signal bundle
interface control_unit_if;
  logic [6:0] instruction_opcode;
  logic       memory_response;
  logic       memory_read;
  logic       memory_write;
  logic       lorD;
  logic       ir_write;
  logic       mdr_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic [1:0] aluop;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       is_immediate;
  logic       reg_write;
  logic [1:0] memory_to_reg;
  logic       illegal_instr;
  logic       bus_error;
  logic [3:0] state_out;

  modport master (
    input  instruction_opcode, memory_response,
    output memory_read, memory_write, lorD, ir_write, mdr_write, pc_write,
           pc_write_cond, pc_source, aluop, alu_src_a, alu_src_b, is_immediate,
           reg_write, memory_to_reg, illegal_instr, bus_error, state_out
  );

  modport slave (
    output instruction_opcode, memory_response,
    input  memory_read, memory_write, lorD, ir_write, mdr_write, pc_write,
           pc_write_cond, pc_source, aluop, alu_src_a, alu_src_b, is_immediate,
           reg_write, memory_to_reg, illegal_instr, bus_error, state_out
  );
endinterface

// File: rtl/control_unit_mem_wait_timer.sv
// rtl/control_unit_mem_wait_timer.sv - counts unanswered memory wait cycles and flags a timeout
module control_unit_mem_wait_timer #(
  parameter int MEM_TIMEOUT   = 0,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_waiting,
  input  logic i_response,
  output logic o_timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST =
    TIMEOUT_WIDTH'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [TIMEOUT_WIDTH-1:0] r_count;

  // A response in the last allowed cycle still wins over the timeout.
  assign o_timeout = (MEM_TIMEOUT != 0) && i_waiting && !i_response && (r_count == LP_LAST);

  // Any cycle that leaves or is outside a wait state clears, so each entry starts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_waiting && !i_response && !o_timeout) begin
      r_count <= r_count + TIMEOUT_WIDTH'(1);
    end else begin
      r_count <= '0;
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV32I main control FSM
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects and enables.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 0,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);

  state_t    r_state;
  state_t    w_next;
  ctrl_out_t w_out;
  logic      w_timeout;
  logic      w_resp;

  assign w_resp = bus.memory_response;

  control_unit_mem_wait_timer #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_waiting (is_wait_state(r_state)),
    .i_response(w_resp),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_out  = '0;
    case (r_state)
      S_FETCH: begin
        w_out.memory_read = 1'b1;
        w_out.alu_src_a   = SRC_A_PC;
        w_out.alu_src_b   = SRC_B_FOUR;
        w_out.aluop       = ALUOP_ADD;
        if (w_resp) begin
          w_out.ir_write = 1'b1;
          w_out.pc_write = 1'b1;
          w_next         = S_DECODE;
        end else if (w_timeout) begin
          w_out.bus_error = 1'b1;
        end
      end
      S_DECODE: begin
        w_out.alu_src_a = SRC_A_PC_OLD;
        w_out.alu_src_b = SRC_B_IMM;
        case (bus.instruction_opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_JAL:             w_next = S_JAL;
          OP_JALR:            w_next = S_EXEC_JALR;
          OP_LUI:             w_next = S_EXEC_LUI;
          OP_AUIPC:           w_next = S_EXEC_AUIPC;
          OP_FENCE, OP_SYSTEM: w_next = S_FETCH;
          default: begin
            w_out.illegal_instr = 1'b1;
            w_next              = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        w_out.alu_src_a = SRC_A_RS1;
        w_out.alu_src_b = SRC_B_RS2;
        w_out.aluop     = ALUOP_FUNCT;
        w_next          = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_out.alu_src_a    = SRC_A_RS1;
        w_out.alu_src_b    = SRC_B_IMM;
        w_out.aluop        = ALUOP_FUNCT;
        w_out.is_immediate = 1'b1;
        w_next             = S_ALU_WB;
      end
      S_EXEC_LUI: begin
        w_out.alu_src_a = SRC_A_ZERO;
        w_out.alu_src_b = SRC_B_IMM;
        w_next          = S_ALU_WB;
      end
      S_EXEC_AUIPC: begin
        w_out.alu_src_a = SRC_A_PC_OLD;
        w_out.alu_src_b = SRC_B_IMM;
        w_next          = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_out.reg_write     = 1'b1;
        w_out.memory_to_reg = M2R_ALU;
        w_next              = S_FETCH;
      end
      S_BRANCH: begin
        w_out.alu_src_a     = SRC_A_RS1;
        w_out.alu_src_b     = SRC_B_RS2;
        w_out.aluop         = ALUOP_BRANCH;
        w_out.pc_write_cond = 1'b1;
        w_out.pc_source     = 1'b1;
        w_next              = S_FETCH;
      end
      S_JAL, S_JALR_WB: begin
        w_out.reg_write     = 1'b1;
        w_out.memory_to_reg = M2R_PC;
        w_out.pc_write      = 1'b1;
        w_out.pc_source     = 1'b1;
        w_next              = S_FETCH;
      end
      S_EXEC_JALR: begin
        w_out.alu_src_a = SRC_A_RS1;
        w_out.alu_src_b = SRC_B_IMM;
        w_next          = S_JALR_WB;
      end
      S_MEM_ADDR: begin
        w_out.alu_src_a = SRC_A_RS1;
        w_out.alu_src_b = SRC_B_IMM;
        w_next          = bus.instruction_opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_out.memory_read = 1'b1;
        w_out.lord        = 1'b1;
        if (w_resp) begin
          w_out.mdr_write = 1'b1;
          w_next          = S_MEM_WB;
        end else if (w_timeout) begin
          w_out.bus_error = 1'b1;
          w_next          = S_FETCH;
        end
      end
      S_MEM_WB: begin
        w_out.reg_write     = 1'b1;
        w_out.memory_to_reg = M2R_MDR;
        w_next              = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_out.memory_write = 1'b1;
        w_out.lord         = 1'b1;
        if (w_resp) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_out.bus_error = 1'b1;
          w_next          = S_FETCH;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are gated by reset so an access in flight is dropped the moment reset falls.
  assign {bus.memory_read, bus.memory_write, bus.lorD, bus.ir_write, bus.mdr_write,
          bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.aluop, bus.alu_src_a,
          bus.alu_src_b, bus.is_immediate, bus.reg_write, bus.memory_to_reg,
          bus.illegal_instr, bus.bus_error} = reset ? w_out : '0;
  assign bus.state_out = r_state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized transaction-level check of control_unit
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int TMO = 4;

  localparam logic [23:0] M_MR   = 24'h800000;
  localparam logic [23:0] M_MW   = 24'h400000;
  localparam logic [23:0] M_LORD = 24'h200000;
  localparam logic [23:0] M_IRW  = 24'h100000;
  localparam logic [23:0] M_MDRW = 24'h080000;
  localparam logic [23:0] M_PCW  = 24'h040000;
  localparam logic [23:0] M_PCC  = 24'h020000;
  localparam logic [23:0] M_PCS  = 24'h010000;
  localparam logic [23:0] M_IMM  = 24'h000200;
  localparam logic [23:0] M_RW   = 24'h000100;
  localparam logic [23:0] M_ILL  = 24'h000020;
  localparam logic [23:0] M_BE   = 24'h000010;

  typedef struct {
    logic        resp;
    logic [6:0]  op;
    logic [23:0] exp;
  } cyc_t;

  logic clk;
  logic reset;
  control_unit_if bus();

  control_unit #(.MEM_TIMEOUT(TMO), .TIMEOUT_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [23:0] obs;
  assign obs = {bus.memory_read, bus.memory_write, bus.lorD, bus.ir_write, bus.mdr_write,
                bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.aluop, bus.alu_src_a,
                bus.alu_src_b, bus.is_immediate, bus.reg_write, bus.memory_to_reg,
                bus.illegal_instr, bus.bus_error, bus.state_out};

  cyc_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [6:0] legal_ops [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] ev(input logic [3:0] st, input logic [1:0] aop,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] m2r, input logic [23:0] fl);
    return fl | {8'b0, aop, sa, sb, 2'b0, m2r, 2'b0, st};
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  task automatic push(input logic r, input logic [6:0] op, input logic [23:0] e);
    cyc_t c;
    c.resp = r;
    c.op   = op;
    c.exp  = e;
    q.push_back(c);
  endtask

  // One memory wait phase: w idle cycles then a response, unless the timeout fires first.
  task automatic phase(input logic [23:0] base, input logic [23:0] extra, input int w,
                       output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k == w) begin
        push(1'b1, rnd_op(), base | extra);
        ok = 1'b1;
        break;
      end
      if (k == TMO - 1) begin
        push(1'b0, rnd_op(), base | M_BE);
        break;
      end
      push(1'b0, rnd_op(), base);
    end
  endtask

  task automatic gen_instr(input logic [6:0] op, input int w0, input int w1);
    bit ok;
    bit legal;
    phase(ev(S_FETCH, 2'b00, 2'b00, 2'b01, 2'b00, M_MR), M_IRW | M_PCW, w0, ok);
    if (!ok) return;
    legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    push(1'($urandom), op, ev(S_DECODE, 2'b00, 2'b10, 2'b10, 2'b00, legal ? 24'h0 : M_ILL));
    case (op)
      OP_R: begin
        push(1'($urandom), rnd_op(), ev(S_EXEC_R, 2'b10, 2'b01, 2'b00, 2'b00, 24'h0));
        push(1'($urandom), rnd_op(), ev(S_ALU_WB, 2'b00, 2'b00, 2'b00, 2'b00, M_RW));
      end
      OP_I: begin
        push(1'($urandom), rnd_op(), ev(S_EXEC_I, 2'b10, 2'b01, 2'b10, 2'b00, M_IMM));
        push(1'($urandom), rnd_op(), ev(S_ALU_WB, 2'b00, 2'b00, 2'b00, 2'b00, M_RW));
      end
      OP_LUI: begin
        push(1'($urandom), rnd_op(), ev(S_EXEC_LUI, 2'b00, 2'b11, 2'b10, 2'b00, 24'h0));
        push(1'($urandom), rnd_op(), ev(S_ALU_WB, 2'b00, 2'b00, 2'b00, 2'b00, M_RW));
      end
      OP_AUIPC: begin
        push(1'($urandom), rnd_op(), ev(S_EXEC_AUIPC, 2'b00, 2'b10, 2'b10, 2'b00, 24'h0));
        push(1'($urandom), rnd_op(), ev(S_ALU_WB, 2'b00, 2'b00, 2'b00, 2'b00, M_RW));
      end
      OP_BRANCH:
        push(1'($urandom), rnd_op(), ev(S_BRANCH, 2'b01, 2'b01, 2'b00, 2'b00, M_PCC | M_PCS));
      OP_JAL:
        push(1'($urandom), rnd_op(), ev(S_JAL, 2'b00, 2'b00, 2'b00, 2'b10, M_RW | M_PCW | M_PCS));
      OP_JALR: begin
        push(1'($urandom), rnd_op(), ev(S_EXEC_JALR, 2'b00, 2'b01, 2'b10, 2'b00, 24'h0));
        push(1'($urandom), rnd_op(), ev(S_JALR_WB, 2'b00, 2'b00, 2'b00, 2'b10, M_RW | M_PCW | M_PCS));
      end
      OP_LOAD: begin
        push(1'($urandom), op, ev(S_MEM_ADDR, 2'b00, 2'b01, 2'b10, 2'b00, 24'h0));
        phase(ev(S_MEM_READ, 2'b00, 2'b00, 2'b00, 2'b00, M_MR | M_LORD), M_MDRW, w1, ok);
        if (ok) push(1'($urandom), rnd_op(), ev(S_MEM_WB, 2'b00, 2'b00, 2'b00, 2'b01, M_RW));
      end
      OP_STORE: begin
        push(1'($urandom), op, ev(S_MEM_ADDR, 2'b00, 2'b01, 2'b10, 2'b00, 24'h0));
        phase(ev(S_MEM_WRITE, 2'b00, 2'b00, 2'b00, 2'b00, M_MW | M_LORD), 24'h0, w1, ok);
      end
      default: ;
    endcase
  endtask

  // Called right at a falling edge; each entry is driven, checked 1 unit later, then one cycle passes.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.memory_response    = c.resp;
      bus.instruction_opcode = c.op;
      #1;
      check_vec($sformatf("cyc%0d_st%0d", cyc, c.exp[3:0]), obs, c.exp);
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int pick;
    int w0;
    int w1;
    logic [6:0] op;
    legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                  OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM};
    reset                  = 1'b0;
    bus.memory_response    = 1'b1;
    bus.instruction_opcode = 7'h7f;
    repeat (2) @(negedge clk);
    #1;
    check_vec("reset_outputs", obs, 24'h0);
    @(negedge clk);
    reset = 1'b1;

    gen_instr(OP_R, 2, 0);
    gen_instr(OP_LOAD, 0, 2);
    gen_instr(OP_STORE, 1, 3);
    gen_instr(OP_BRANCH, 0, 0);
    gen_instr(OP_JAL, 0, 0);
    gen_instr(7'h7f, 0, 0);
    gen_instr(OP_LOAD, 0, 5);
    gen_instr(OP_I, 4, 0);
    gen_instr(OP_JALR, 3, 0);
    gen_instr(OP_LUI, 0, 0);
    gen_instr(OP_AUIPC, 1, 0);
    gen_instr(OP_FENCE, 0, 0);
    gen_instr(OP_SYSTEM, 0, 0);
    gen_instr(OP_STORE, 0, 4);
    run_queue();

    // Store left waiting in MEM_WRITE, then reset pulled mid-access.
    gen_instr(OP_STORE, 0, 2);
    while (q.size() > 0 && q[q.size()-1].exp[3:0] != 4'(S_MEM_ADDR)) void'(q.pop_back());
    push(1'b0, rnd_op(), ev(S_MEM_WRITE, 2'b00, 2'b00, 2'b00, 2'b00, M_MW | M_LORD));
    push(1'b0, rnd_op(), ev(S_MEM_WRITE, 2'b00, 2'b00, 2'b00, 2'b00, M_MW | M_LORD));
    run_queue();
    bus.memory_response = 1'b1;
    reset               = 1'b0;
    #1;
    check_vec("reset_mid_write", obs, 24'h0);
    @(negedge clk);
    reset = 1'b1;

    repeat (300) begin
      pick = $urandom_range(0, 11);
      op   = (pick < 11) ? legal_ops[pick] : rnd_op();
      w0   = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
      w1   = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      gen_instr(op, w0, w1);
      run_queue();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
